// File: rtl/thd_pkg.sv
// Shared types and width helpers for the THD engine: FSM states, derived widths
// and the legal harmonic-count range.
package thd_pkg;

    localparam int NH_MIN = 2;
    localparam int NH_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        SQRT,
        DIV,
        DONE
    } state_e;

    // Accumulator holds up to NH_MAX full-width squares without overflow.
    function automatic int calc_aw(input int dw);
        return 2 * dw + 4;
    endfunction

    function automatic int calc_rw(input int dw);
        return calc_aw(dw) / 2;
    endfunction

endpackage

// File: rtl/thd_sqrt_iter.sv
// Restoring integer square root, one root bit per cycle, MSB first.
// start_i marks the first iteration cycle; done_o marks the last one.
module thd_sqrt_iter
    import thd_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [calc_aw(DW)-1:0]    radicand_i,
    output logic [calc_rw(DW)-1:0]    root_o,
    output logic                      done_o
);
    localparam int AW = calc_aw(DW);
    localparam int RW = calc_rw(DW);
    localparam int SW = RW + 3;
    localparam int CW = $clog2(RW);

    logic [AW-1:0] x_q, x_src;
    logic [SW-1:0] rem_q, rem_src, rem_sh, trial;
    logic [RW-1:0] root_q, root_src;
    logic [CW-1:0] cnt_q, cnt_src;
    logic          run_q, active, ge;

    // NOTE: every always_comb output gets a default on every path, so no latch is inferred.
    always_comb begin
        active   = start_i || run_q;
        x_src    = start_i ? radicand_i : x_q;
        rem_src  = start_i ? '0 : rem_q;
        root_src = start_i ? '0 : root_q;
        cnt_src  = start_i ? '0 : cnt_q;
        rem_sh   = (rem_src << 2) | SW'(x_src[AW-1 -: 2]);
        trial    = SW'({root_src, 2'b01});
        ge       = rem_sh >= trial;
        done_o   = active && (cnt_src == CW'(RW - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else if (active) begin
            x_q    <= x_src << 2;
            rem_q  <= ge ? rem_sh - trial : rem_sh;
            root_q <= (root_src << 1) | RW'(ge);
            cnt_q  <= cnt_src + 1'b1;
            run_q  <= !done_o;
        end
    end

    assign root_o = root_q;

endmodule

// File: rtl/thd_engine.sv
// THD = sqrt(sum Hk^2, k=2..N) / H1 as an unsigned fixed-point ratio, computed by a
// sequential accumulate / square-root / divide datapath with fixed latency.
module thd_engine
    import thd_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NH   = 5,
    parameter int FRAC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      num_harm,
    input  logic [NH*DW-1:0] harm_i,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   thd_q,
    output logic            div_zero,
    output logic            sat
);
    localparam int AW = calc_aw(DW);
    localparam int RW = calc_rw(DW);
    localparam int QW = RW + FRAC;
    localparam int CW = $clog2(QW);

    state_e          state_q;
    logic [DW-1:0]   h_q [NH];
    logic [4:0]      nh_q, nh_d, k_q;
    logic [DW-1:0]   h_sel;
    logic [2*DW-1:0] sq;
    logic [AW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   rem_q, rem_d, rem_src;
    logic [DW:0]     trial;
    logic [QW-1:0]   quo_q, quo_d, quo_src;
    logic            ge;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   root;
    logic            sqrt_start, sqrt_done;

    always_comb begin
        nh_d = num_harm;
        if (num_harm < 5'(NH_MIN))
            nh_d = 5'(NH_MIN);
        else if (num_harm > 5'(NH))
            nh_d = 5'(NH);

        h_sel = '0;
        for (int i = 1; i < NH; i++)
            if (k_q == 5'(i + 1))
                h_sel = h_q[i];
        sq    = (2*DW)'(h_sel) * (2*DW)'(h_sel);
        acc_d = acc_q + AW'(sq);

        // First DIV cycle seeds the divider from the root instead of the registers.
        rem_src = (cnt_q == '0) ? '0 : rem_q;
        quo_src = (cnt_q == '0) ? (QW'(root) << FRAC) : quo_q;
        trial   = {rem_src, quo_src[QW-1]};
        ge      = trial >= {1'b0, h_q[0]};
        rem_d   = ge ? DW'(trial - {1'b0, h_q[0]}) : trial[DW-1:0];
        quo_d   = (quo_src << 1) | QW'(ge);

        sqrt_start = (state_q == SQRT) && (cnt_q == '0);
    end

    thd_sqrt_iter #(.DW(DW)) u_sqrt (
        .clk        (clk),
        .rst        (rst),
        .start_i    (sqrt_start),
        .radicand_i (acc_q),
        .root_o     (root),
        .done_o     (sqrt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            thd_q    <= '0;
            div_zero <= 1'b0;
            sat      <= 1'b0;
            nh_q     <= 5'(NH_MIN);
            k_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            // NOTE: the harmonic bank is a handful of flops, so it is reset like any other state.
            for (int i = 0; i < NH; i++)
                h_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    for (int i = 0; i < NH; i++)
                        h_q[i] <= harm_i[i*DW +: DW];
                    nh_q    <= nh_d;
                    k_q     <= 5'd2;
                    acc_q   <= '0;
                    busy    <= 1'b1;
                    state_q <= ACC;
                end
                ACC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 5'd1;
                    if (k_q == nh_q) begin
                        cnt_q   <= '0;
                        state_q <= SQRT;
                    end
                end
                SQRT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sqrt_done) begin
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(QW - 1)) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                        if (h_q[0] == '0) begin
                            thd_q    <= '1;
                            div_zero <= 1'b1;
                            sat      <= 1'b0;
                        end else if (quo_d[QW-1:DW] != '0) begin
                            thd_q    <= '1;
                            div_zero <= 1'b0;
                            sat      <= 1'b1;
                        end else begin
                            thd_q    <= quo_d[DW-1:0];
                            div_zero <= 1'b0;
                            sat      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
